// File: rtl/sar_pkg.sv
// Shared definitions for the SAR scan controller: FSM state encoding and default sizing.
package sar_pkg;

  localparam int SAR_N_BITS        = 8;
  localparam int SAR_N_CH          = 4;
  localparam int SAR_SAMPLE_CYCLES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_SET,
    ST_CMP,
    ST_HOLD
  } sar_state_e;

endpackage

// File: rtl/sar_cmp_sync.sv
// Two-flop synchronizer for the asynchronous comparator output of the analog macro.
module sar_cmp_sync (
  input  logic clk,
  input  logic rst,
  input  logic ena_i,
  input  logic cmp_i,
  output logic cmp_sync_o
);

  logic [1:0] sync_q;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else if (ena_i) begin
      sync_q <= {sync_q[0], cmp_i};
    end
  end

  assign cmp_sync_o = sync_q[1];

endmodule

// File: rtl/sar_scan_ctrl.sv
// SAR scan controller: ascending masked-channel scan, binary-search conversion, valid/ready results.
// Build option SAR_CMP_SYNC_EN: cmp_in goes through sar_cmp_sync and CMP is stretched to 3 cycles.
module sar_scan_ctrl
  import sar_pkg::*;
#(
  parameter int N_BITS        = SAR_N_BITS,
  parameter int N_CH          = SAR_N_CH,
  parameter int SAMPLE_CYCLES = SAR_SAMPLE_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     start,
  input  logic                     cont,
  input  logic [N_CH-1:0]          ch_mask,
  input  logic                     cmp_in,
  output logic                     sample_o,
  output logic [$clog2(N_CH)-1:0]  ch_sel_o,
  output logic [N_BITS-1:0]        dac_code_o,
  output logic                     busy,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [N_BITS-1:0]        res_data,
  output logic [$clog2(N_CH)-1:0]  res_ch
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int BIT_W = $clog2(N_BITS);
  localparam int SMP_W = $clog2(SAMPLE_CYCLES + 1);
`ifdef SAR_CMP_SYNC_EN
  localparam int CMP_CYCLES = 3;
`else
  localparam int CMP_CYCLES = 1;
`endif

  sar_state_e        state_q;
  logic [N_CH-1:0]   mask_q;
  logic [BIT_W-1:0]  bit_q;
  logic [SMP_W-1:0]  smp_cnt_q;
  logic [1:0]        cmp_cnt_q;
  logic              cmp_bit;
  logic [N_BITS-1:0] bit_mask;
  logic [N_BITS-1:0] code_kept;
  logic [CH_W-1:0]   low_in_ch;
  logic [CH_W-1:0]   low_q_ch;
  logic [CH_W-1:0]   next_ch;
  logic              next_found;

`ifdef SAR_CMP_SYNC_EN
  sar_cmp_sync u_cmp_sync (
    .clk        (clk),
    .rst        (rst),
    .ena_i      (ena),
    .cmp_i      (cmp_in),
    .cmp_sync_o (cmp_bit)
  );
`else
  assign cmp_bit = cmp_in;
`endif

  // The trial code lives in dac_code_o itself; a low comparator clears the bit under test.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    bit_mask        = '0;
    bit_mask[bit_q] = 1'b1;
    code_kept       = cmp_bit ? dac_code_o : (dac_code_o & ~bit_mask);
  end

  always_comb begin
    low_in_ch  = '0;
    low_q_ch   = '0;
    next_ch    = '0;
    next_found = 1'b0;
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (ch_mask[c]) low_in_ch = CH_W'(c);
      if (mask_q[c])  low_q_ch  = CH_W'(c);
      if (mask_q[c] && (c > int'(ch_sel_o))) begin
        next_ch    = CH_W'(c);
        next_found = 1'b1;
      end
    end
  end

  // HOLD bypasses ena so an accepted result is always retired.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mask_q     <= '0;
      bit_q      <= '0;
      smp_cnt_q  <= '0;
      cmp_cnt_q  <= '0;
      sample_o   <= 1'b0;
      ch_sel_o   <= '0;
      dac_code_o <= '0;
      busy       <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_ch     <= '0;
    end else if (ena || (state_q == ST_HOLD)) begin
      case (state_q)
        ST_IDLE: begin
          if (start && (ch_mask != '0)) begin
            mask_q     <= ch_mask;
            ch_sel_o   <= low_in_ch;
            smp_cnt_q  <= SMP_W'(SAMPLE_CYCLES - 1);
            sample_o   <= 1'b1;
            dac_code_o <= '0;
            busy       <= 1'b1;
            state_q    <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (smp_cnt_q == '0) begin
            sample_o   <= 1'b0;
            bit_q      <= BIT_W'(N_BITS - 1);
            dac_code_o <= {1'b1, {(N_BITS - 1){1'b0}}};
            state_q    <= ST_SET;
          end else begin
            smp_cnt_q <= smp_cnt_q - 1'b1;
          end
        end
        ST_SET: begin
          cmp_cnt_q <= 2'(CMP_CYCLES - 1);
          state_q   <= ST_CMP;
        end
        ST_CMP: begin
          if (cmp_cnt_q != '0) begin
            cmp_cnt_q <= cmp_cnt_q - 1'b1;
          end else if (bit_q != '0) begin
            dac_code_o <= code_kept | (bit_mask >> 1);
            bit_q      <= bit_q - 1'b1;
            state_q    <= ST_SET;
          end else begin
            res_data   <= code_kept;
            res_ch     <= ch_sel_o;
            res_valid  <= 1'b1;
            dac_code_o <= '0;
            state_q    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (next_found || cont) begin
              ch_sel_o  <= next_found ? next_ch : low_q_ch;
              smp_cnt_q <= SMP_W'(SAMPLE_CYCLES - 1);
              sample_o  <= 1'b1;
              state_q   <= ST_SAMPLE;
            end else begin
              busy    <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_scan_ctrl.sv
// Self-checking bench for sar_scan_ctrl: ideal comparator model, directed timing cases, randomized scans.
module tb_sar_scan_ctrl;
  import sar_pkg::*;

  localparam int N_BITS = SAR_N_BITS;
  localparam int N_CH   = SAR_N_CH;
  localparam int SC     = SAR_SAMPLE_CYCLES;
`ifdef SAR_CMP_SYNC_EN
  localparam int TRIAL = 4;
`else
  localparam int TRIAL = 2;
`endif
  localparam int LAT = SC + TRIAL * N_BITS;

  logic                    clk = 1'b0;
  logic                    rst, ena, start, cont, cmp_in, res_ready;
  logic [N_CH-1:0]         ch_mask;
  logic                    sample_o, busy, res_valid;
  logic [$clog2(N_CH)-1:0] ch_sel_o, res_ch;
  logic [N_BITS-1:0]       dac_code_o, res_data;
  logic [N_BITS-1:0]       vin [N_CH];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int t_ref = 0;
  bit rand_ena = 1'b0;

  sar_scan_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .start      (start),
    .cont       (cont),
    .ch_mask    (ch_mask),
    .cmp_in     (cmp_in),
    .sample_o   (sample_o),
    .ch_sel_o   (ch_sel_o),
    .dac_code_o (dac_code_o),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_ch     (res_ch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Ideal analog macro: comparator high when the selected input is at or above the DAC level.
  assign cmp_in = (vin[ch_sel_o] >= dac_code_o);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ena = rand_ena ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sample"}, 32'(sample_o), 0);
    check({tag, "_busy"},   32'(busy), 0);
    check({tag, "_valid"},  32'(res_valid), 0);
    check({tag, "_dac"},    32'(dac_code_o), 0);
    check({tag, "_data"},   32'(res_data), 0);
    check({tag, "_rch"},    32'(res_ch), 0);
    check({tag, "_chsel"},  32'(ch_sel_o), 0);
  endtask

  // Edge E0 is the tick inside; the mask is scrambled afterwards to show it was latched.
  task automatic do_start(input logic [N_CH-1:0] m);
    ch_mask = m;
    start   = 1'b1;
    ena     = 1'b1;
    tick();
    start   = 1'b0;
    t_ref   = cyc;
    ch_mask = ~m;
  endtask

  // Wait for one result, compare against the model, stall `hold` cycles, then hand it off.
  task automatic collect(input int exp_ch, input int exp_code, input int hold, input bit chk_lat);
    int n = 0;
    res_ready = 1'b0;
    while (!res_valid && n < 400) begin
      check("ch_sel", 32'(ch_sel_o), exp_ch);
      tick();
      n++;
    end
    if (!res_valid) begin
      check("result_timeout", 0, 1);
      return;
    end
    if (chk_lat) check("latency", cyc - t_ref, LAT);
    check("res_ch", 32'(res_ch), exp_ch);
    check("res_data", 32'(res_data), exp_code);
    check("hold_dac", 32'(dac_code_o), 0);
    for (int k = 0; k < hold; k++) begin
      tick();
      check("stall_valid", 32'(res_valid), 1);
      check("stall_data", 32'(res_data), exp_code);
      check("stall_ch", 32'(res_ch), exp_ch);
      check("stall_sample", 32'(sample_o), 0);
    end
    res_ready = 1'b1;
    tick();
    t_ref     = cyc;
    res_ready = 1'b0;
    check("hs_drop", 32'(res_valid), 0);
  endtask

  function automatic logic [N_BITS-1:0] pick_vin();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      default: return N_BITS'($urandom_range(0, (1 << N_BITS) - 1));
    endcase
  endfunction

  initial begin
    logic [N_CH-1:0] m;
    logic [N_BITS-1:0] v;
    rst = 1'b1; ena = 1'b1; start = 1'b0; cont = 1'b0;
    ch_mask = '0; res_ready = 1'b0;
    for (int c = 0; c < N_CH; c++) vin[c] = '0;
    repeat (3) tick();
    check_reset_outputs("rst");
    rst = 1'b0;
    tick();

    // Single channel, with the first two bit trials traced explicitly.
    vin[0] = 8'hA5;
    do_start(4'b0001);
    check("e0_sample", 32'(sample_o), 1);
    check("e0_busy", 32'(busy), 1);
    check("e0_dac", 32'(dac_code_o), 0);
    check("e0_ch", 32'(ch_sel_o), 0);
    for (int k = 1; k < SC; k++) begin
      tick();
      check("sample_len", 32'(sample_o), 1);
    end
    tick();
    check("set_sample", 32'(sample_o), 0);
    check("set_dac", 32'(dac_code_o), 32'h80);
    for (int k = 1; k < TRIAL; k++) begin
      tick();
      check("cmp_dac", 32'(dac_code_o), 32'h80);
    end
    tick();
    check("set2_dac", 32'(dac_code_o), 32'hC0);
    collect(0, 32'hA5, 0, 1'b1);
    check("single_idle", 32'(busy), 0);
    check("single_nosample", 32'(sample_o), 0);

    vin[0] = 8'h5A;
    do_start(4'b0001);
    collect(0, 32'h5A, 0, 1'b1);
    check("single2_idle", 32'(busy), 0);

    // Multi-channel ascending order with boundary codes.
    vin[0] = 8'h11; vin[1] = 8'h00; vin[2] = 8'h22; vin[3] = 8'hFF;
    do_start(4'b1010);
    check("mc_first_ch", 32'(ch_sel_o), 1);
    collect(1, 32'h00, 0, 1'b1);
    check("mc_bubble", 32'(sample_o), 1);
    check("mc_next_ch", 32'(ch_sel_o), 3);
    collect(3, 32'hFF, 0, 1'b1);
    check("mc_idle", 32'(busy), 0);

    // Backpressure: ten stalled cycles, then zero-bubble start of ch1.
    for (int c = 0; c < N_CH; c++) vin[c] = pick_vin();
    do_start(4'b0111);
    collect(0, 32'(vin[0]), 10, 1'b1);
    check("bp_bubble", 32'(sample_o), 1);
    check("bp_next_ch", 32'(ch_sel_o), 1);
    collect(1, 32'(vin[1]), 0, 1'b1);
    collect(2, 32'(vin[2]), 3, 1'b1);
    check("bp_idle", 32'(busy), 0);

    // Continuous mode; a mid-conversion start with another mask must be ignored.
    cont = 1'b1;
    vin[0] = pick_vin();
    do_start(4'b0001);
    repeat (7) tick();
    ch_mask = 4'b1110;
    start = 1'b1;
    tick();
    start = 1'b0;
    collect(0, 32'(vin[0]), 2, 1'b1);
    check("cont_restart", 32'(sample_o), 1);
    check("cont_busy", 32'(busy), 1);
    v = pick_vin(); vin[0] = v;
    collect(0, 32'(v), 0, 1'b1);
    cont = 1'b0;
    v = pick_vin(); vin[0] = v;
    collect(0, 32'(v), 0, 1'b1);
    check("cont_stop", 32'(busy), 0);

    // Reset during the bit-4 trial, then a zero-mask start.
    vin[0] = 8'h77;
    do_start(4'b0001);
    repeat (SC + TRIAL * 3 + 1) tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy), 0);
    ch_mask = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("zmask_busy", 32'(busy), 0);
    check("zmask_sample", 32'(sample_o), 0);
    repeat (3) tick();
    check("zmask_busy_late", 32'(busy), 0);

    // Randomized scans with ena toggling; model is channel order plus ideal code = vin.
    rand_ena = 1'b1;
    for (int s = 0; s < 8; s++) begin
      m = N_CH'($urandom_range(1, (1 << N_CH) - 1));
      for (int c = 0; c < N_CH; c++) vin[c] = pick_vin();
      do_start(m);
      for (int c = 0; c < N_CH; c++)
        if (m[c]) collect(c, 32'(vin[c]), $urandom_range(0, 3), 1'b0);
      check("rnd_idle", 32'(busy), 0);
    end
    rand_ena = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/sar_scan_ctrl.md
# sar_scan_ctrl

Digital sequencer for the on-die SAR converter built from the analog macro on the `ua` pins: capacitive DAC, comparator and input mux. It scans a masked set of analog channels in ascending order. For each channel it drives sample, mux select and DAC trial codes, and it resolves the result by binary search on the comparator output. Results go out over a valid/ready handshake. It sits between the analog macro and the `uo_out`/`uio` readout logic inside the top-level tile.

## Interface
Parameters:
- `N_BITS`, default 8: conversion resolution.
- `N_CH`, default 4: number of analog channels (at most 6, the usable `ua[5:0]`).
- `SAMPLE_CYCLES`, default 4: length of the sample phase in cycles, at least 1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  tile clock.
- `rst`  in  1  synchronous active-high reset.
- `ena`  in  1  0 freezes all state and outputs; 1 runs.
- `start`  in  1  begins a scan. Honoured only in IDLE.
- `cont`  in  1  checked at end of scan; 1 restarts the scan automatically.
- `ch_mask`  in  N_CH  channels to convert. Captured at `start`.
- `cmp_in`  in  1  comparator output from the analog macro; 1 means Vin ≥ Vdac.
- `sample_o`  out  1  closes the sample switch.
- `ch_sel_o`  out  $clog2(N_CH)  analog mux select.
- `dac_code_o`  out  N_BITS  DAC trial code.
- `busy`  out  1  high in any state other than IDLE.
- `res_valid`  out  1  a result is available.
- `res_ready`  in  1  the consumer accepts the result.
- `res_data`  out  N_BITS  converted code.
- `res_ch`  out  $clog2(N_CH)  channel of `res_data`.

## Operation
- FSM states: IDLE, SAMPLE, SET, CMP, HOLD.
- **IDLE**
  - `start`=1 with `ch_mask`≠0: latch the mask, set `ch_sel_o` to the lowest set bit, go to SAMPLE.
  - `start`=1 with `ch_mask`=0: ignored.
- **SAMPLE**
  - `sample_o`=1 and `dac_code_o`=0 for exactly SAMPLE_CYCLES cycles.
  - Then bit index i=N_BITS-1, go to SET.
- **SET** (1 cycle)
  - `dac_code_o` = accumulated code with bit i set; `sample_o`=0.
  - Go to CMP.
- **CMP**
  - `cmp_in` is sampled at the closing edge. Bit i is kept if `cmp_in`=1 and cleared if 0.
  - If i>0: decrement i, go to SET.
  - If i=0: load `res_data` and `res_ch`, assert `res_valid`, go to HOLD.
  - `dac_code_o` holds the SET value throughout CMP.
- **HOLD**
  - `dac_code_o`=0. `res_valid`, `res_data` and `res_ch` are held stable until `res_ready`=1.
  - On the handshake edge, `res_valid` deasserts, then:
    - next higher masked channel exists: go to SAMPLE on that channel;
    - no more channels and `cont`=1: return to the lowest masked channel (same latched mask) and go to SAMPLE;
    - otherwise: go to IDLE.
- Backpressure: no new sample begins while a result is unaccepted. Results are never dropped or overwritten.
- `start` while `busy`=1: ignored. Changes to `ch_mask` mid-scan: no effect.
- `ena`=0: state, counters and all outputs freeze; `cmp_in` is not sampled. The handshake still completes if `res_ready`=1.
- Reset values:
  - state IDLE;
  - `sample_o`, `busy`, `res_valid` = 0;
  - `dac_code_o`, `res_data`, `res_ch`, `ch_sel_o` = 0.
- Reset mid-conversion: the partial result is discarded and all outputs take their reset values on the next edge.

## Timing
- Edge E0 is the edge that samples `start`. `sample_o` is high in the cycles after E0, E0+1 … E0+SAMPLE_CYCLES-1.
- Each bit trial takes 2 cycles (SET + CMP). `res_valid` rises at edge E0 + SAMPLE_CYCLES + 2·N_BITS; this is 20 cycles at defaults.
- After a handshake at edge H, `sample_o` for the next channel rises at H (zero bubble).
- `cmp_in` must be settled by the final edge of CMP. The DAC gets one full SET cycle plus the CMP cycle to settle.

## Configuration
- `SAR_CMP_SYNC_EN` defined:
  - `cmp_in` passes through a 2-flop synchronizer;
  - CMP lasts 3 cycles and samples the synchronized value on its third edge;
  - each bit trial takes 4 cycles, so latency is SAMPLE_CYCLES + 4·N_BITS (36 at defaults).
- `SAR_CMP_SYNC_EN` undefined: `cmp_in` is used directly and CMP is 1 cycle.

## Structure
- Shared package `sar_pkg`: FSM state enum and the default constants for N_BITS, N_CH and SAMPLE_CYCLES.
- Sub-module `sar_cmp_sync`: the 2-flop synchronizer. It is instantiated only under `SAR_CMP_SYNC_EN`. The bit-trial CMP length is derived from the same macro.

## Test plan
The bench comparator model is `cmp_in = (vin[ch] >= dac_code_o)`. All scenarios use default parameters.
- Single channel: mask=0001, vin0=0xA5, `start` -> `res_valid` 20 cycles after E0, `res_data`=0xA5, `res_ch`=0, then IDLE with `busy`=0.
- Multi-channel order: mask=1010, vin1=0x00, vin3=0xFF -> results (ch1, 0x00) then (ch3, 0xFF); channels 0 and 2 are never selected.
- Backpressure: mask=0111, `res_ready` held low 10 cycles after the first result -> `res_valid` and `res_data` stable and `sample_o` low for those 10 cycles; ch1 sampling starts on the handshake edge.
- Continuous mode with ignored starts: `cont`=1, mask=0001, `start` pulsed mid-conversion -> back-to-back ch0 results with period 20 plus handshake latency; the extra `start` has no effect.
- Reset and zero mask: `rst` asserted during bit 4 trial -> all outputs 0 on the next edge. `start` with mask=0 -> `busy` stays 0.
- Config build: with `SAR_CMP_SYNC_EN` defined, vin0=0x5A -> `res_data`=0x5A at 36 cycles after E0.
